// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, device ACK check.
// Shares the open-collector ps2c/ps2d pins with the receiver; busy tells the receiver to ignore traffic.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_tx_done,
    output logic       o_tx_error,
    output logic       o_busy,
    input  logic       i_ps2c_in,
    input  logic       i_ps2d_in,
    output logic       o_ps2c_oe,
    output logic       o_ps2d_oe
);

    localparam int CW = $clog2(INHIBIT_CYCLES + SETUP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_c_sync, r_d_sync;
    logic [FILTER_LEN-1:0] r_c_hist, r_d_hist;
    logic                  r_c_filt, r_c_filt_q, r_d_filt;
    logic [CW-1:0]         r_cnt;
    logic [TW-1:0]         r_to;
    logic [3:0]            r_edges;
    logic [7:0]            r_data;
    logic                  r_par;
    logic                  r_d_oe;
    logic                  r_ack_ok;
    logic                  w_fall_c;
    logic                  w_in_xfer;
    logic                  w_timeout;
    logic                  w_line_idle;
    logic                  w_inh_done;
    logic                  w_setup_done;

    // Lines idle high, so the synchronisers and filters reset to 1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_c_sync   <= 2'b11;
            r_d_sync   <= 2'b11;
            r_c_hist   <= '1;
            r_d_hist   <= '1;
            r_c_filt   <= 1'b1;
            r_c_filt_q <= 1'b1;
            r_d_filt   <= 1'b1;
        end else begin
            r_c_sync   <= {r_c_sync[0], i_ps2c_in};
            r_d_sync   <= {r_d_sync[0], i_ps2d_in};
            r_c_hist   <= {r_c_hist[FILTER_LEN-2:0], r_c_sync[1]};
            r_d_hist   <= {r_d_hist[FILTER_LEN-2:0], r_d_sync[1]};
            if (&r_c_hist)       r_c_filt <= 1'b1;
            else if (~|r_c_hist) r_c_filt <= 1'b0;
            if (&r_d_hist)       r_d_filt <= 1'b1;
            else if (~|r_d_hist) r_d_filt <= 1'b0;
            r_c_filt_q <= r_c_filt;
        end
    end

    assign w_fall_c     = r_c_filt_q & ~r_c_filt;
    assign w_line_idle  = r_c_filt & r_d_filt;
    assign w_in_xfer    = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout    = w_in_xfer && (r_to == TW'(TIMEOUT_CYCLES));
    assign w_inh_done   = (r_cnt == CW'(INHIBIT_CYCLES - 1));
    assign w_setup_done = (r_cnt == CW'(SETUP_CYCLES - 1));
    assign o_ps2d_oe    = r_d_oe;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_tx_start) w_next = S_INHIBIT;
            S_INHIBIT:   if (w_inh_done) w_next = S_REQ;
            S_REQ:       if (w_setup_done) w_next = S_SHIFT;
            S_SHIFT:     if (w_timeout) w_next = S_IDLE;
                         else if (w_fall_c && r_edges == 4'd9) w_next = S_ACK;
            S_ACK:       if (w_timeout) w_next = S_IDLE;
                         else if (w_fall_c) w_next = S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_timeout || w_line_idle) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_ready = (r_state == S_IDLE);
        o_busy     = (r_state != S_IDLE);
        o_ps2c_oe  = (r_state == S_INHIBIT) || (r_state == S_REQ);
        o_tx_done  = (r_state == S_WAIT_IDLE) && !w_timeout && w_line_idle && r_ack_ok;
        o_tx_error = w_timeout || ((r_state == S_WAIT_IDLE) && w_line_idle && !r_ack_ok);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_to     <= '0;
            r_edges  <= '0;
            r_data   <= '0;
            r_par    <= 1'b0;
            r_d_oe   <= 1'b0;
            r_ack_ok <= 1'b0;
        end else begin
            if ((r_state == S_INHIBIT || r_state == S_REQ) && w_next == r_state)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            if (w_in_xfer && w_next != S_IDLE) r_to <= r_to + 1'b1;
            else                               r_to <= '0;

            if (r_state == S_IDLE && i_tx_start) begin
                r_data <= i_tx_data;
                r_par  <= ~^i_tx_data;
            end

            if (r_state == S_REQ && w_next == S_SHIFT)
                r_edges <= '0;
            else if (w_fall_c && (r_state == S_SHIFT || r_state == S_ACK) && r_edges < 4'd11)
                r_edges <= r_edges + 1'b1;

            // Data only moves on a filtered clock fall; the start bit is asserted on entry to REQ.
            if (w_next == S_IDLE)
                r_d_oe <= 1'b0;
            else if (r_state == S_INHIBIT && w_next == S_REQ)
                r_d_oe <= 1'b1;
            else if (r_state == S_SHIFT && w_fall_c) begin
                if (r_edges < 4'd8)       r_d_oe <= ~r_data[r_edges[2:0]];
                else if (r_edges == 4'd8) r_d_oe <= ~r_par;
                else                      r_d_oe <= 1'b0;
            end

            if (r_state == S_ACK && w_fall_c) r_ack_ok <= ~r_d_filt;
        end
    end

endmodule
